// File: rtl/fetch_pc_ctrl.sv
// Fetch PC controller: sequential fetch with a valid/ready handshake to instruction memory,
// taken-branch redirects with a fixed-length pipeline flush, and a misaligned-target error pulse.
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    input  logic        branch_valid,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        stall,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic        fetch_valid,
    output logic [31:0] fetch_pc,
    output logic        flush,
    output logic        misalign_err,
    output logic [15:0] redirect_cnt
);

    localparam logic [0:0] ST_FETCH   = 1'b0;
    localparam logic [0:0] ST_FLUSH   = 1'b1;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    logic [0:0]  r_state;
    logic [2:0]  r_flush_cnt;
    logic [31:0] r_pc;
    logic [31:0] r_fetch_pc;
    logic        r_fetch_valid;
    logic        r_misalign;
    logic [15:0] r_redirect_cnt;
    logic        r_req_en;
    logic        r_pending;

    logic w_branch_hit;
    logic w_redirect;
    logic w_misalign;
    logic w_req;
    logic w_accept;
    logic w_unused;

    assign w_unused     = &{1'b0, inst[31:7]};
    assign w_branch_hit = branch_valid && (inst[6:0] == OPC_BRANCH) && branch_taken;
    assign w_redirect   = w_branch_hit && (branch_target[1:0] == 2'b00);
    assign w_misalign   = w_branch_hit && (branch_target[1:0] != 2'b00);

    // A request already presented but not yet accepted stays up even if stall rises.
    assign w_req    = r_req_en && (r_state == ST_FETCH) && (!stall || r_pending);
    assign w_accept = w_req && imem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_FETCH;
            r_flush_cnt    <= 3'd0;
            r_pc           <= RESET_PC;
            r_fetch_pc     <= 32'h0000_0000;
            r_fetch_valid  <= 1'b0;
            r_misalign     <= 1'b0;
            r_redirect_cnt <= 16'h0000;
            r_req_en       <= 1'b0;
            r_pending      <= 1'b0;
        end else begin
            r_req_en      <= 1'b1;
            r_misalign    <= w_misalign;
            r_fetch_valid <= w_accept && !w_redirect;
            if (w_redirect) begin
                // Redirect wins over stall and any same-cycle handshake.
                r_pc        <= branch_target;
                r_state     <= ST_FLUSH;
                r_flush_cnt <= FLUSH_LOAD;
                r_pending   <= 1'b0;
                if (r_redirect_cnt != 16'hFFFF) begin
                    r_redirect_cnt <= r_redirect_cnt + 16'd1;
                end
            end else begin
                if (w_accept) begin
                    r_pc       <= r_pc + 32'd4;
                    r_fetch_pc <= r_pc;
                end
                r_pending <= w_req && !imem_ready;
                if (r_state == ST_FLUSH) begin
                    if (r_flush_cnt == 3'd0) begin
                        r_state <= ST_FETCH;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 3'd1;
                    end
                end
            end
        end
    end

    assign imem_req     = w_req;
    assign imem_addr    = r_pc;
    assign pc           = r_pc;
    assign fetch_valid  = r_fetch_valid;
    assign fetch_pc     = r_fetch_pc;
    assign flush        = (r_state == ST_FLUSH);
    assign misalign_err = r_misalign;
    assign redirect_cnt = r_redirect_cnt;

endmodule
